// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: MD op codes, FSM states, op-class helpers.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_calc(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational MD datapath: 64-bit product or quotient/remainder from the latched op and operands.
// Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        wr_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic        sgn;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    hi_o  = '0;
    lo_o  = '0;
    wr_o  = 1'b0;
    sgn   = (op_i == MD_MULT) || (op_i == MD_DIV);
    a_ext = sgn ? {{32{a_i[31]}}, a_i} : {32'h0, a_i};
    b_ext = sgn ? {{32{b_i[31]}}, b_i} : {32'h0, b_i};
    prod  = a_ext * b_ext;
    a_mag = (sgn && a_i[31]) ? (~a_i + 32'd1) : a_i;
    b_mag = (sgn && b_i[31]) ? (~b_i + 32'd1) : b_i;
    q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    neg_q = sgn && (a_i[31] ^ b_i[31]);
    neg_r = sgn && a_i[31];

    if ((op_i == MD_MULT) || (op_i == MD_MULTU)) begin
      wr_o = 1'b1;
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end else if (is_md_div(op_i)) begin
      // A zero divisor leaves HI/LO untouched.
      wr_o = (b_i != 32'd0);
      lo_o = neg_q ? (~q_mag + 32'd1) : q_mag;
      hi_o = neg_r ? (~r_mag + 32'd1) : r_mag;
    end
  end

endmodule

// File: rtl/md_sched.sv
// MD sequencer: fixed-latency busy counter, HI/LO ownership, MF/MT service and D-stage stall request.
// Results come only from operands latched at start, so E-stage forwarding may change during RUN.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;

  logic        start_md;
  logic        calc_wr;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;

  md_calc u_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .wr_o (calc_wr),
    .hi_o (calc_hi),
    .lo_o (calc_lo)
  );

  assign start_md = start && is_md_calc(md_op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start_md) begin
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = is_md_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          state_d = ST_RUN;
        end else if (start && (md_op == MD_MTHI)) begin
          hi_d = src_a;
        end else if (start && (md_op == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      ST_RUN: begin
        // A start arriving here is illegal and deliberately ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (calc_wr) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign md_stall = md_use_D && (start_md || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_data  = (md_op == MD_MFHI) ? hi_q :
                    (md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule
